// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_add.sv
// 1-bit full-adder cell; the only arithmetic element in the serial datapath.
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial W-bit adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell, followed by a registered done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int            CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  logic [W-1:0]   a_sr;
  logic [W-1:0]   b_sr;
  logic           carry;
  logic [CW-1:0]  count;
  logic           fa_s;
  logic           fa_c;

  full_add u_full_add (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // NOTE: every register here, state and datapath alike, is assigned with <= so
  // that all of them sample the same pre-edge values of a_sr, b_sr and carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            a_sr  <= a;
            b_sr  <= (sub == MODE_SUB) ? ~b : b;
            carry <= (sub == MODE_SUB);
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= {fa_s, result[W-1:1]};
          carry  <= fa_c;
          count  <= count + 1'b1;
          if (count == LAST) begin
            // carry still holds the carry into the MSB on this final step.
            overflow <= carry ^ fa_c;
            cout     <= fa_c;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (W = 8): directed cases, start-while-busy,
// mid-operation reset, then randomized operations against an arithmetic model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  serial_addsub #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic s,
                                output logic [7:0] r, output logic c, output logic v);
    int ux, uy, sx, sy, full, sfull;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      full  = ux - uy;
      sfull = sx - sy;
      c     = (ux >= uy);
    end else begin
      full  = ux + uy;
      sfull = sx + sy;
      c     = (full > 255);
    end
    r = full[7:0];
    v = (sfull > 127) || (sfull < -128);
  endfunction

  // Drives one start pulse; returns #1 after the accepting edge, inputs scrambled.
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic s);
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    sub   = 1'($urandom);
  endtask

  // Counts cycles after the start edge until done, and busy samples on the way.
  task automatic wait_done(output int lat, output int busy_n, output bit ok);
    lat    = 0;
    busy_n = 0;
    ok     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input bit timing,
                        input logic [7:0] er, input logic ec, input logic ev);
    int lat, bn;
    bit ok;
    launch(x, y, s);
    wait_done(lat, bn, ok);
    check({tag, " done_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, " result"}, 32'(result), 32'(er));
      check({tag, " cout"}, 32'(cout), 32'(ec));
      check({tag, " overflow"}, 32'(overflow), 32'(ev));
      if (timing) begin
        check({tag, " latency"}, 32'(lat), 32'(W + 1));
        check({tag, " busy_cycles"}, 32'(bn), 32'(W));
      end
    end
  endtask

  initial begin
    logic [7:0] rx, ry, rr;
    logic       rs, rc, rv;
    int         lat, bn, done_cnt;
    bit         ok;

    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add 100+27", 8'd100, 8'd27, 1'b0, 1'b1, 8'd127, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done one pulse", 32'(done), 32'd0);
    check("result holds", 32'(result), 32'd127);

    run_op("add 200+100", 8'd200, 8'd100, 1'b0, 1'b1, 8'd44, 1'b1, 1'b0);
    run_op("add 127+1", 8'd127, 8'd1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    run_op("sub 5-7", 8'd5, 8'd7, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub 7-5", 8'd7, 8'd5, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
    run_op("sub 80-1", 8'h80, 8'd1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start pulsed on the third busy cycle must be ignored.
    launch(8'd50, 8'd60, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'd1; b = 8'd1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bn, ok);
    check("ignored start done_seen", 32'(ok), 32'd1);
    check("ignored start result", 32'(result), 32'd110);
    check("ignored start latency", 32'(lat), 32'(W + 1 - 3));
    // Back-to-back: start during the done cycle is taken by the IDLE edge.
    run_op("back2back sub 3-9", 8'd3, 8'd9, 1'b1, 1'b1, 8'hFA, 1'b0, 1'b0);

    // Reset during the fourth busy cycle aborts asynchronously.
    launch(8'd10, 8'd20, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("pre-abort busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    done_cnt = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    check("idle after abort", 32'(done_cnt), 32'd0);
    run_op("post-reset 3+4", 8'd3, 8'd4, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rs = 1'($urandom);
      model(rx, ry, rs, rr, rc, rv);
      run_op($sformatf("rnd%0d %s %0h,%0h", n, rs ? "sub" : "add", rx, ry),
             rx, ry, rs, (n % 50) == 0, rr, rc, rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
